l2_mem_ctrl: RTL and testbench

L2_MEM_CTRL -- requirements
Module: l2_mem_ctrl

---
 rtl/l2_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_l2_mem_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_ctrl.sv
// l2_mem_ctrl: splits 64-bit doubleword read/write requests from the bus
// controller into two 32-bit word beats toward memory (low word first).
//
// Parameters:
//   TIMEOUT   - consecutive memwait-high cycles within one beat before the
//               transaction is abandoned with L2_ERROR.
// Ports:
//   CLK, RST  - clock; synchronous active-high reset
//   l2REN/l2WEN, l2addr, l2store - doubleword request (write has priority)
//   l2load    - read data, updated only by read-beat capture or buffer hit
//   l2state   - FREE=0, BUSY=1, ACCESS=2, ERROR=3
//   memREN/memWEN, memaddr, memstore - word strobes, address and write data
//   memload, memwait - word read data; high memwait stretches the beat
// Build option:
//   L2_LINE_BUFFER_EN - adds a one-entry doubleword buffer; reads that hit it
//                       complete without any memory access.
module l2_mem_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        l2REN,
    input  logic        l2WEN,
    input  logic [31:0] l2addr,
    input  logic [63:0] l2store,
    output logic [63:0] l2load,
    output logic [1:0]  l2state,
    output logic        memREN,
    output logic        memWEN,
    output logic [31:0] memaddr,
    output logic [31:0] memstore,
    input  logic [31:0] memload,
    input  logic        memwait
);

    localparam logic [1:0] L2_FREE   = 2'd0;
    localparam logic [1:0] L2_BUSY   = 2'd1;
    localparam logic [1:0] L2_ACCESS = 2'd2;
    localparam logic [1:0] L2_ERROR  = 2'd3;

    // Counter only needs to hold 0..TIMEOUT-1.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StRd0, StRd1, StWr0, StWr1, StDone, StErr} state_t;

    state_t          state_q;
    logic [28:0]     dw_addr_q;  // latched doubleword address (byte address [31:3])
    logic [63:0]     data_q;
    logic [63:0]     load_q;
    logic [CntW-1:0] cnt_q;

    logic in_rd, in_wr, beat_hi;

    // Byte-lane bits of the request address carry no information.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^l2addr[2:0];

`ifdef L2_LINE_BUFFER_EN
    logic        buf_valid_q;
    logic [28:0] buf_addr_q;
    logic [63:0] buf_data_q;
    logic        buf_hit;

    assign buf_hit = buf_valid_q && (buf_addr_q == l2addr[31:3]);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            dw_addr_q <= '0;
            data_q    <= '0;
            load_q    <= '0;
            cnt_q     <= '0;
`ifdef L2_LINE_BUFFER_EN
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (l2WEN) begin
                        state_q   <= StWr0;
                        dw_addr_q <= l2addr[31:3];
                        data_q    <= l2store;
`ifdef L2_LINE_BUFFER_EN
                        // Write-through: the entry tracks the latest write.
                        buf_valid_q <= 1'b1;
                        buf_addr_q  <= l2addr[31:3];
                        buf_data_q  <= l2store;
`endif
                    end else if (l2REN) begin
                        dw_addr_q <= l2addr[31:3];
                        data_q    <= l2store;
`ifdef L2_LINE_BUFFER_EN
                        if (buf_hit) begin
                            load_q  <= buf_data_q;
                            state_q <= StDone;
                        end else begin
                            state_q <= StRd0;
                        end
`else
                        state_q <= StRd0;
`endif
                    end
                end
                StRd0, StRd1: begin
                    if (!memwait) begin
                        cnt_q <= '0;
                        if (state_q == StRd0) begin
                            load_q[31:0] <= memload;
                            state_q      <= StRd1;
                        end else begin
                            load_q[63:32] <= memload;
                            state_q       <= StDone;
`ifdef L2_LINE_BUFFER_EN
                            buf_valid_q <= 1'b1;
                            buf_addr_q  <= dw_addr_q;
                            buf_data_q  <= {memload, load_q[31:0]};
`endif
                        end
                    end else if (cnt_q == CntLast) begin
                        state_q <= StErr;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWr0, StWr1: begin
                    if (!memwait) begin
                        cnt_q   <= '0;
                        state_q <= (state_q == StWr0) ? StWr1 : StDone;
                    end else if (cnt_q == CntLast) begin
                        state_q <= StErr;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                StErr: begin
                    state_q <= StIdle;
`ifdef L2_LINE_BUFFER_EN
                    buf_valid_q <= 1'b0;
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Memory-side outputs decode the registered state, so they are stable
    // for the whole beat and drop to zero outside an active beat.
    assign in_rd   = (state_q == StRd0) || (state_q == StRd1);
    assign in_wr   = (state_q == StWr0) || (state_q == StWr1);
    assign beat_hi = (state_q == StRd1) || (state_q == StWr1);

    assign memREN   = in_rd;
    assign memWEN   = in_wr;
    assign memaddr  = (in_rd || in_wr) ? {dw_addr_q, beat_hi, 2'b00} : '0;
    assign memstore = in_wr ? (beat_hi ? data_q[63:32] : data_q[31:0]) : '0;
    assign l2load   = load_q;

    always_comb begin
        l2state = L2_FREE;
        unique case (state_q)
            StIdle:                     l2state = L2_FREE;
            StRd0, StRd1, StWr0, StWr1: l2state = L2_BUSY;
            StDone:                     l2state = L2_ACCESS;
            StErr:                      l2state = L2_ERROR;
            default:                    l2state = L2_FREE;
        endcase
    end

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Bench for l2_mem_ctrl. A transaction-level model turns each request plus
// the memory wait schedule into the expected per-cycle output sequence; one
// monitor compares it every cycle and also acts as the word memory.
module tb_l2_mem_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        l2REN, l2WEN;
    logic [31:0] l2addr;
    logic [63:0] l2store;
    logic [63:0] l2load;
    logic [1:0]  l2state;
    logic        memREN, memWEN;
    logic [31:0] memaddr, memstore, memload;
    logic        memwait;

    always #5 CLK = ~CLK;

    l2_mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .l2REN    (l2REN),
        .l2WEN    (l2WEN),
        .l2addr   (l2addr),
        .l2store  (l2store),
        .l2load   (l2load),
        .l2state  (l2state),
        .memREN   (memREN),
        .memWEN   (memWEN),
        .memaddr  (memaddr),
        .memstore (memstore),
        .memload  (memload),
        .memwait  (memwait)
    );

    typedef struct {
        logic [1:0]  st;
        logic        ren;
        logic        wen;
        logic        chk_addr;
        logic [31:0] addr;
        logic        chk_store;
        logic [31:0] store;
        logic [63:0] load;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    logic [31:0] mem [logic [31:0]];
    int unsigned mem_waits = 0;
    int unsigned wait_cnt = 0;
    logic [63:0] exp_load = '0;

    // Observation logs, cleared at each transaction start.
    int          acc_count, busy_count, ren_count, acc_cyc;
    logic [31:0] beat_addr[$];
    logic [31:0] beat_data[$];

`ifdef L2_LINE_BUFFER_EN
    logic        bvalid = 1'b0;
    logic [31:0] baddr = '0;
    logic [63:0] bdata = '0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic exp_t mk(input logic [1:0] st, input logic ren, input logic wen,
                                input logic [31:0] a, input logic [31:0] s,
                                input logic [63:0] ld);
        exp_t e;
        e.st = st; e.ren = ren; e.wen = wen;
        e.chk_addr = ren | wen; e.addr = a;
        e.chk_store = wen; e.store = s;
        e.load = ld;
        return e;
    endfunction

    task automatic buf_fill(input logic [31:0] a, input logic [63:0] d);
`ifdef L2_LINE_BUFFER_EN
        bvalid = 1'b1; baddr = a; bdata = d;
`endif
    endtask

    task automatic buf_clear();
`ifdef L2_LINE_BUFFER_EN
        bvalid = 1'b0;
`endif
    endtask

    // Model: a read is two beats of (waits+1) BUSY cycles, then one ACCESS.
    task automatic model_read(input logic [31:0] a_in, input int unsigned w);
        logic [31:0] a;
        logic        hit;
        a = a_in & ~32'h7;
        hit = 1'b0;
`ifdef L2_LINE_BUFFER_EN
        hit = bvalid && (baddr == a);
        if (hit) begin
            exp_load = bdata;
            exp_q.push_back(mk(ACC, 1'b0, 1'b0, 32'h0, 32'h0, exp_load));
        end
`endif
        if (!hit) begin
            repeat (w + 1) exp_q.push_back(mk(BUSY, 1'b1, 1'b0, a, 32'h0, exp_load));
            exp_load[31:0] = rd_word(a);
            repeat (w + 1) exp_q.push_back(mk(BUSY, 1'b1, 1'b0, a + 32'd4, 32'h0, exp_load));
            exp_load[63:32] = rd_word(a + 32'd4);
            exp_q.push_back(mk(ACC, 1'b0, 1'b0, 32'h0, 32'h0, exp_load));
            buf_fill(a, exp_load);
        end
    endtask

    // Model: memory never answers, so TIMEOUT BUSY cycles then one ERROR.
    task automatic model_read_stuck(input logic [31:0] a_in);
        logic [31:0] a;
        a = a_in & ~32'h7;
        repeat (TIMEOUT) exp_q.push_back(mk(BUSY, 1'b1, 1'b0, a, 32'h0, exp_load));
        exp_q.push_back(mk(ERR, 1'b0, 1'b0, 32'h0, 32'h0, exp_load));
        buf_clear();
    endtask

    task automatic model_write(input logic [31:0] a_in, input logic [63:0] d,
                               input int unsigned w);
        logic [31:0] a;
        a = a_in & ~32'h7;
        buf_fill(a, d);
        repeat (w + 1) exp_q.push_back(mk(BUSY, 1'b0, 1'b1, a, d[31:0], exp_load));
        repeat (w + 1) exp_q.push_back(mk(BUSY, 1'b0, 1'b1, a + 32'd4, d[63:32], exp_load));
        exp_q.push_back(mk(ACC, 1'b0, 1'b0, 32'h0, 32'h0, exp_load));
    endtask

    // Monitor and memory responder.
    initial begin
        exp_t e;
        memwait = 1'b0;
        memload = 32'hDEAD_BEEF;
        forever begin
            @(negedge CLK);
            cyc++;
            if (mon_en) begin
                check("strobe_exclusive", 64'(memREN & memWEN), 64'h0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("l2state", 64'(l2state), 64'(e.st));
                    check("memREN", 64'(memREN), 64'(e.ren));
                    check("memWEN", 64'(memWEN), 64'(e.wen));
                    if (e.chk_addr) check("memaddr", 64'(memaddr), 64'(e.addr));
                    if (e.chk_store) check("memstore", 64'(memstore), 64'(e.store));
                    check("l2load", l2load, e.load);
                end else begin
                    check("idle_state", 64'(l2state), 64'(FREE));
                    check("idle_strobes", 64'({memREN, memWEN}), 64'h0);
                    check("idle_l2load", l2load, exp_load);
                end
                if (l2state == ACC) begin acc_count++; acc_cyc = cyc; end
                if (l2state == BUSY) busy_count++;
                if (memREN) ren_count++;
            end
            if (memREN || memWEN) begin
                if (wait_cnt < mem_waits) begin
                    memwait = 1'b1;
                    wait_cnt++;
                    memload = 32'hDEAD_BEEF;
                end else begin
                    memwait = 1'b0;
                    wait_cnt = 0;
                    if (memWEN) begin
                        mem[memaddr] = memstore;
                        beat_data.push_back(memstore);
                    end else begin
                        memload = rd_word(memaddr);
                        beat_data.push_back(memload);
                    end
                    beat_addr.push_back(memaddr);
                end
            end else begin
                memwait = 1'b0;
                wait_cnt = 0;
                memload = 32'hDEAD_BEEF;
            end
        end
    end

    task automatic begin_txn(output int c0);
        @(negedge CLK);
        #2;
        c0 = cyc;
        acc_count = 0; busy_count = 0; ren_count = 0; acc_cyc = 0;
        beat_addr.delete();
        beat_data.delete();
    endtask

    // Request for one cycle, then scramble inputs to show they are ignored.
    task automatic drive(input logic ren, input logic wen, input logic [31:0] a,
                         input logic [63:0] d);
        l2REN = ren; l2WEN = wen; l2addr = a; l2store = d;
        @(posedge CLK);
        #2;
        l2REN = 1'b0; l2WEN = 1'b0; l2addr = 32'hFFFF_FFF8; l2store = '1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK);
        check("drain", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        int c0;
        RST = 1'b1; l2REN = 1'b0; l2WEN = 1'b0; l2addr = '0; l2store = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_l2state", 64'(l2state), 64'h0);
        check("rst_strobes", 64'({memREN, memWEN}), 64'h0);
        check("rst_memaddr", 64'(memaddr), 64'h0);
        check("rst_memstore", 64'(memstore), 64'h0);
        check("rst_l2load", l2load, 64'h0);
        #2;
        RST = 1'b0;
        mon_en = 1'b1;

        // Zero-wait read from an unaligned address.
        mem[32'h1000] = 32'hAAAA_0001;
        mem[32'h1004] = 32'hBBBB_0002;
        mem_waits = 0;
        begin_txn(c0);
        model_read(32'h0000_1004, 0);
        drive(1'b1, 1'b0, 32'h0000_1004, 64'h0);
        drain();
        check("rd_l2load", l2load, 64'hBBBB0002_AAAA0001);
        check("rd_access_cycle", 64'(acc_cyc - c0), 64'd3);
        check("rd_beats", 64'(beat_addr.size()), 64'd2);
        if (beat_addr.size() == 2) begin
            check("rd_beat0_addr", 64'(beat_addr[0]), 64'h1000);
            check("rd_beat1_addr", 64'(beat_addr[1]), 64'h1004);
        end

        // Write with three wait cycles per beat.
        mem_waits = 3;
        begin_txn(c0);
        model_write(32'h2000, 64'h11223344_55667788, 3);
        drive(1'b0, 1'b1, 32'h2000, 64'h11223344_55667788);
        drain();
        check("wr_beats", 64'(beat_addr.size()), 64'd2);
        if (beat_addr.size() == 2) begin
            check("wr_beat0_addr", 64'(beat_addr[0]), 64'h2000);
            check("wr_beat0_data", 64'(beat_data[0]), 64'h55667788);
            check("wr_beat1_addr", 64'(beat_addr[1]), 64'h2004);
            check("wr_beat1_data", 64'(beat_data[1]), 64'h11223344);
        end
        check("wr_access_cycles", 64'(acc_count), 64'd1);
        check("wr_l2load_kept", l2load, 64'hBBBB0002_AAAA0001);

        // Read and write together: the write wins.
        mem_waits = 1;
        begin_txn(c0);
        model_write(32'h2800, 64'hCAFEF00D_12345678, 1);
        drive(1'b1, 1'b1, 32'h2800, 64'hCAFEF00D_12345678);
        drain();
        check("both_no_memREN", 64'(ren_count), 64'h0);
        check("both_mem_lo", 64'(rd_word(32'h2800)), 64'h12345678);
        check("both_mem_hi", 64'(rd_word(32'h2804)), 64'hCAFEF00D);

        // Memory stuck busy: error after TIMEOUT cycles, then a clean read.
        mem_waits = 1000;
        begin_txn(c0);
        model_read_stuck(32'h1000);
        drive(1'b1, 1'b0, 32'h1000, 64'h0);
        drain();
        check("to_busy_cycles", 64'(busy_count), 64'd8);
        check("to_no_access", 64'(acc_count), 64'h0);
        mem_waits = 0;
        begin_txn(c0);
        model_read(32'h2000, 0);
        drive(1'b1, 1'b0, 32'h2000, 64'h0);
        drain();
        check("to_next_read", l2load, 64'h11223344_55667788);

        // Reset during the second read beat.
        mem_waits = 3;
        begin_txn(c0);
        repeat (4) exp_q.push_back(mk(BUSY, 1'b1, 1'b0, 32'h1000, 32'h0, exp_load));
        exp_load[31:0] = rd_word(32'h1000);
        exp_q.push_back(mk(BUSY, 1'b1, 1'b0, 32'h1004, 32'h0, exp_load));
        exp_load = '0;
        exp_q.push_back('{st: FREE, ren: 1'b0, wen: 1'b0, chk_addr: 1'b1, addr: 32'h0,
                          chk_store: 1'b1, store: 32'h0, load: 64'h0});
        buf_clear();
        drive(1'b1, 1'b0, 32'h1000, 64'h0);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        drain();
        check("rst_mid_l2load", l2load, 64'h0);

`ifdef L2_LINE_BUFFER_EN
        // Buffer: miss, hit, write-through update, hit with new data.
        mem[32'h3000] = 32'h3000_0000;
        mem[32'h3004] = 32'h3000_0004;
        mem_waits = 0;
        begin_txn(c0);
        model_read(32'h3000, 0);
        drive(1'b1, 1'b0, 32'h3000, 64'h0);
        drain();
        begin_txn(c0);
        model_read(32'h3000, 0);
        drive(1'b1, 1'b0, 32'h3000, 64'h0);
        drain();
        check("hit_no_memREN", 64'(ren_count), 64'h0);
        check("hit_access_cycle", 64'(acc_cyc - c0), 64'd1);
        check("hit_l2load", l2load, 64'h30000004_30000000);
        begin_txn(c0);
        model_write(32'h3000, 64'h99998888_77776666, 0);
        drive(1'b0, 1'b1, 32'h3000, 64'h99998888_77776666);
        drain();
        begin_txn(c0);
        model_read(32'h3000, 0);
        drive(1'b1, 1'b0, 32'h3000, 64'h0);
        drain();
        check("wt_hit_no_memREN", 64'(ren_count), 64'h0);
        check("wt_hit_l2load", l2load, 64'h99998888_77776666);
`endif

        repeat (3) @(negedge CLK);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "time limit reached");
    end

endmodule
